// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake: single-cycle logic/arith ops plus
// iterative shift-add MUL and restoring DIVU/REMU, one bit per cycle.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            ALUOp,
    input  logic [6:0]            Funct7,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic [3:0]            Operation,
    output logic                  Illegal
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010,
        OP_XOR  = 4'b1100,
        OP_ILL  = 4'b1111
    } op_e;

    state_e state_q, state_nx;
    op_e    base_op, dec_op, op_q;
    logic   is_multi;
    logic   accept;

    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] acc_q, opa_q, opb_q;
    logic [DATA_WIDTH-1:0] acc_nx, opa_nx, opb_nx, iter_res;
    logic [DATA_WIDTH:0]   rem_shift, diff;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    // Funct3 map shared by R-type Funct7=0000000 and all I-type instructions.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        base_op = OP_ILL;
        case (Funct3)
            3'b000:  base_op = OP_ADD;
            3'b111:  base_op = OP_AND;
            3'b110:  base_op = OP_OR;
            3'b100:  base_op = OP_XOR;
            3'b010:  base_op = OP_SLT;
            default: base_op = OP_ILL;
        endcase
    end

    always_comb begin
        dec_op = OP_ILL;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                if (Funct7 == 7'b0000000) begin
                    dec_op = base_op;
                end else if (Funct7 == 7'b0100000 && Funct3 == 3'b000) begin
                    dec_op = OP_SUB;
                end else if (Funct7 == 7'b0000001) begin
                    case (Funct3)
                        3'b000:  dec_op = OP_MUL;
                        3'b101:  dec_op = OP_DIVU;
                        3'b111:  dec_op = OP_REMU;
                        default: dec_op = OP_ILL;
                    endcase
                end
            end
            default: dec_op = base_op;
        endcase
    end

    assign is_multi = (dec_op == OP_MUL) || (dec_op == OP_DIVU) || (dec_op == OP_REMU);

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: alu_res = '0;
        endcase
    end

    // One iteration: MUL uses acc=product, opa=shifted multiplicand, opb=remaining multiplier;
    // DIVU/REMU use acc=partial remainder, opa=dividend becoming quotient, opb=divisor.
    // A zero divisor never borrows, which yields all-ones quotient and remainder=A for free.
    assign rem_shift = {acc_q, opa_q[DATA_WIDTH-1]};
    assign diff      = rem_shift - {1'b0, opb_q};

    always_comb begin
        acc_nx = acc_q;
        opa_nx = opa_q;
        opb_nx = opb_q;
        if (op_q == OP_MUL) begin
            acc_nx = opb_q[0] ? acc_q + opa_q : acc_q;
            opa_nx = opa_q << 1;
            opb_nx = opb_q >> 1;
        end else begin
            acc_nx = diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
            opa_nx = {opa_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        end
    end

    assign iter_res = (op_q == OP_DIVU) ? opa_nx : acc_nx;

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (accept) state_nx = is_multi ? BUSY : DONE;
            BUSY:    if (count_q == CW'(1)) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            op_q      <= OP_AND;
            Result    <= '0;
            Zero      <= 1'b1;
            Operation <= 4'b0000;
            Illegal   <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            if (is_multi) begin
                count_q <= CW'(DATA_WIDTH);
                op_q    <= dec_op;
            end else begin
                Result    <= alu_res;
                Zero      <= (alu_res == '0);
                Operation <= dec_op;
                Illegal   <= (dec_op == OP_ILL);
            end
        end else if (state_q == BUSY) begin
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
                Result    <= iter_res;
                Zero      <= (iter_res == '0);
                Operation <= op_q;
                Illegal   <= 1'b0;
            end
        end
    end

    // NOTE: the iteration datapath is not reset; it is always fully loaded on accept before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && accept) begin
            acc_q <= '0;
            opa_q <= A;
            opb_q <= B;
        end else if (state_q == BUSY) begin
            acc_q <= acc_nx;
            opa_q <= opa_nx;
            opb_q <= opb_nx;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: a 32-bit instance for most scenarios
// and an 8-bit instance for the narrow-width rerun.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready;
    logic [1:0]  aluop;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;
    logic [3:0]  operation;

    logic        in_valid8, out_ready8;
    logic [7:0]  a8, b8, result8;
    logic        in_ready8, out_valid8, zero8, illegal8;
    logic [3:0]  operation8;

    int passed = 0;
    int total  = 0;
    int busy_rdy_err;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(aluop), .Funct7(f7), .Funct3(f3), .A(a), .B(b),
        .out_valid(out_valid), .out_ready(out_ready), .Result(result),
        .Zero(zero), .Operation(operation), .Illegal(illegal)
    );

    alu_exec_unit #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUOp(aluop), .Funct7(f7), .Funct3(f3), .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .Result(result8),
        .Zero(zero8), .Operation(operation8), .Illegal(illegal8)
    );

    // Drives one request on the 32-bit unit and counts rising edges until out_valid.
    // With hold set, in_valid stays high and A is scrambled while the unit is busy.
    task automatic run_op(input logic [1:0] op, input logic [6:0] fs7, input logic [2:0] fs3,
                          input logic [31:0] va, input logic [31:0] vb, input bit hold,
                          output int lat);
        @(negedge clk);
        aluop = op; f7 = fs7; f3 = fs3; a = va; b = vb; in_valid = 1'b1;
        lat = 0;
        busy_rdy_err = 0;
        do begin
            @(negedge clk);
            lat++;
            if (hold) a = ~va;
            else      in_valid = 1'b0;
            if (!out_valid && in_ready) busy_rdy_err++;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL handshake_release: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic check_res(input string name, input int lat, input int exp_lat,
                             input logic [31:0] exp_res, input logic [3:0] exp_op,
                             input logic exp_ill);
        total++;
        if (lat !== exp_lat || result !== exp_res || zero !== (exp_res == 32'd0) ||
            operation !== exp_op || illegal !== exp_ill)
            $display("FAIL %s: lat=%0d res=%h zero=%b op=%b ill=%b, expected lat=%0d res=%h zero=%b op=%b ill=%b",
                     name, lat, result, zero, operation, illegal,
                     exp_lat, exp_res, (exp_res == 32'd0), exp_op, exp_ill);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 ||
            operation !== 4'b0000 || illegal !== 1'b0)
            $display("FAIL reset_state: rdy=%b vld=%b res=%h zero=%b op=%b ill=%b, expected 1 0 0 1 0000 0",
                     in_ready, out_valid, result, zero, operation, illegal);
        else passed++;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || result8 !== 8'd0 || zero8 !== 1'b1)
            $display("FAIL reset_state8: rdy=%b vld=%b res=%h zero=%b, expected 1 0 00 1",
                     in_ready8, out_valid8, result8, zero8);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_single_cycle();
        int lat;
        run_op(2'b10, 7'b0000000, 3'b111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, lat);
        check_res("and", lat, 1, 32'h00F0_000F, 4'b0000, 1'b0);
        consume();
        run_op(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd5, 1'b0, lat);
        check_res("sub_zero", lat, 1, 32'd0, 4'b0110, 1'b0);
        consume();
        run_op(2'b10, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        check_res("slt_neg", lat, 1, 32'd1, 4'b0111, 1'b0);
        consume();
        run_op(2'b11, 7'b0100000, 3'b010, 32'd1, 32'hFFFF_FFFF, 1'b0, lat);
        check_res("slti_pos", lat, 1, 32'd0, 4'b0111, 1'b0);
        consume();
        run_op(2'b10, 7'b0000000, 3'b110, 32'h1200_0034, 32'h0056_7800, 1'b0, lat);
        check_res("or", lat, 1, 32'h1256_7834, 4'b0001, 1'b0);
        consume();
        run_op(2'b11, 7'b1111111, 3'b000, 32'd7, 32'd8, 1'b0, lat);
        check_res("addi", lat, 1, 32'd15, 4'b0010, 1'b0);
        consume();
        run_op(2'b00, 7'b0000001, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        check_res("ld_add_wrap", lat, 1, 32'd0, 4'b0010, 1'b0);
        consume();
        run_op(2'b01, 7'b0000001, 3'b111, 32'd3, 32'd5, 1'b0, lat);
        check_res("br_sub", lat, 1, 32'hFFFF_FFFE, 4'b0110, 1'b0);
        consume();
    endtask

    task automatic test_mul();
        int lat;
        run_op(2'b10, 7'b0000001, 3'b000, 32'h0001_0003, 32'h0001_0005, 1'b1, lat);
        check_res("mul", lat, 33, 32'h0008_000F, 4'b1000, 1'b0);
        total++;
        if (busy_rdy_err !== 0)
            $display("FAIL mul_busy_ready: in_ready high in %0d busy cycles, expected 0", busy_rdy_err);
        else passed++;
        consume();
    endtask

    task automatic test_div();
        int lat;
        run_op(2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7, 1'b0, lat);
        check_res("divu", lat, 33, 32'd14, 4'b1001, 1'b0);
        consume();
        run_op(2'b10, 7'b0000001, 3'b111, 32'd100, 32'd7, 1'b0, lat);
        check_res("remu", lat, 33, 32'd2, 4'b1010, 1'b0);
        consume();
        run_op(2'b10, 7'b0000001, 3'b101, 32'd100, 32'd0, 1'b0, lat);
        check_res("divu_by0", lat, 33, 32'hFFFF_FFFF, 4'b1001, 1'b0);
        consume();
        run_op(2'b10, 7'b0000001, 3'b111, 32'd100, 32'd0, 1'b0, lat);
        check_res("remu_by0", lat, 33, 32'd100, 4'b1010, 1'b0);
        consume();
        run_op(2'b10, 7'b0000001, 3'b101, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, lat);
        check_res("divu_big", lat, 33, 32'd1, 4'b1001, 1'b0);
        consume();
    endtask

    task automatic test_illegal_and_hold();
        int lat;
        int unstable = 0;
        run_op(2'b10, 7'b0000011, 3'b000, 32'd9, 32'd4, 1'b0, lat);
        check_res("illegal", lat, 1, 32'd0, 4'b1111, 1'b1);
        consume();
        run_op(2'b10, 7'b0000000, 3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, lat);
        check_res("xor", lat, 1, 32'h5555_5555, 4'b1100, 1'b0);
        in_valid = 1'b1;
        a = 32'd1;
        b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== 32'h5555_5555 || operation !== 4'b1100 || in_ready !== 1'b0 ||
                out_valid !== 1'b1)
                unstable++;
        end
        in_valid = 1'b0;
        total++;
        if (unstable !== 0)
            $display("FAIL done_hold: %0d unstable cycles, expected 0", unstable);
        else passed++;
        consume();
    endtask

    task automatic test_reset_mid_div();
        int lat;
        @(negedge clk);
        aluop = 2'b10; f7 = 7'b0000001; f3 = 3'b101; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1)
            $display("FAIL reset_mid_div: rdy=%b vld=%b res=%h zero=%b, expected 1 0 0 1",
                     in_ready, out_valid, result, zero);
        else passed++;
        run_op(2'b00, 7'b0000000, 3'b000, 32'd2, 32'd3, 1'b0, lat);
        check_res("add_after_reset", lat, 1, 32'd5, 4'b0010, 1'b0);
        consume();
    endtask

    task automatic test_width8();
        int lat;
        logic [7:0] exp_res [2] = '{8'hFF, 8'h0C};
        logic [2:0] fn [2]      = '{3'b000, 3'b101};
        logic [7:0] va [2]      = '{8'd15, 8'd200};
        logic [7:0] vb [2]      = '{8'd17, 8'd16};
        logic [3:0] exp_op [2]  = '{4'b1000, 4'b1001};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            aluop = 2'b10; f7 = 7'b0000001; f3 = fn[k]; a8 = va[k]; b8 = vb[k]; in_valid8 = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                in_valid8 = 1'b0;
                lat++;
            end while (!out_valid8 && lat < 50);
            total++;
            if (lat !== 9 || result8 !== exp_res[k] || operation8 !== exp_op[k] || illegal8 !== 1'b0)
                $display("FAIL w8_op%0d: lat=%0d res=%h op=%b ill=%b, expected lat=9 res=%h op=%b ill=0",
                         k, lat, result8, operation8, illegal8, exp_res[k], exp_op[k]);
            else passed++;
            @(negedge clk);
            out_ready8 = 1'b1;
            @(negedge clk);
            out_ready8 = 1'b0;
            total++;
            if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0)
                $display("FAIL w8_release%0d: rdy=%b vld=%b, expected 1 0", k, in_ready8, out_valid8);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        aluop = 2'b00; f7 = 7'd0; f3 = 3'd0; a = 32'd0; b = 32'd0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_illegal_and_hold();
        test_reset_mid_div();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
